// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: grant encodings and the starve counter type.
package ram_arbiter_pkg;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam int ARB_CNT_W = 8;
  typedef logic [ARB_CNT_W-1:0] arb_cnt_t;
  localparam arb_cnt_t ARB_CNT_MAX = '1;

  // Saturating increment so a long-starved master 1 never wraps back to zero.
  function automatic arb_cnt_t cnt_sat_inc(input arb_cnt_t c);
    return (c == ARB_CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way winner selection; prefer1 breaks ties in favour of requester 1.
module arb_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic prefer1,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = !prefer1;
      gnt1 = prefer1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port data RAM between the core LSU (m0) and the debug/loader port (m1).
// Define RAM_ARB_RR_EN for round-robin; otherwise fixed priority with starvation promotion.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DW           = 32,
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);

  logic prefer1;
  logic winner;
  logic any_gnt;

  // Requests are masked during reset so every output reads zero while rst is high.
  arb_pick2 u_pick (
    .req0    (m0_req_i && !rst),
    .req1    (m1_req_i && !rst),
    .prefer1 (prefer1),
    .gnt0    (m0_gnt_o),
    .gnt1    (m1_gnt_o)
  );

  assign any_gnt = m0_gnt_o || m1_gnt_o;
  assign winner  = m1_gnt_o ? ARB_M1 : ARB_M0;

`ifdef RAM_ARB_RR_EN
  // rr_ptr names the master that wins the next tie; it moves away from each winner.
  logic rr_ptr;

  assign prefer1 = (rr_ptr == ARB_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= ARB_M0;
    end else if (any_gnt) begin
      rr_ptr <= (winner == ARB_M0) ? ARB_M1 : ARB_M0;
    end
  end
`else
  localparam arb_cnt_t LIMIT = arb_cnt_t'(STARVE_LIMIT);

  arb_cnt_t starve_cnt;

  assign prefer1 = (starve_cnt >= LIMIT);

  // Counts consecutive cycles master 1 waits; any grant or dropped request restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!m1_req_i || m1_gnt_o) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= cnt_sat_inc(starve_cnt);
    end
  end
`endif

  always_comb begin
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (any_gnt) begin
      if (winner == ARB_M1) begin
        ram_we_o    = m1_we_i;
        ram_addr_o  = m1_addr_i;
        ram_wdata_o = m1_wdata_i;
      end else begin
        ram_we_o    = m0_we_i;
        ram_addr_o  = m0_addr_i;
        ram_wdata_o = m0_wdata_i;
      end
    end
  end

  // Read data is captured only for the owner; the other master keeps its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_rdata_o  <= '0;
      m1_rdata_o  <= '0;
    end else begin
      m0_rvalid_o <= m0_gnt_o && !m0_we_i;
      m1_rvalid_o <= m1_gnt_o && !m1_we_i;
      if (m0_gnt_o && !m0_we_i) begin
        m0_rdata_o <= ram_rdata_i;
      end
      if (m1_gnt_o && !m1_we_i) begin
        m1_rdata_o <= ram_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small behavioural RAM model.
module tb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [31:0] mem [16];

  int checks;
  int errors;
  logic prev0, prev1, exp1;

  ram_arbiter #(.DW(32), .AW(32), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: word index from address bits [5:2], preloaded with A000_000i on reset.
  assign ram_rdata = mem[ram_addr[5:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (ram_we) begin
      mem[ram_addr[5:2]] <= ram_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    applyStimulus(1, 0, 32'h2000_0000, 0, 1, 0, 32'h2000_0004, 0);
    step();
    step();
    // Reset state with both masters requesting: grants and RAM bus held at zero.
    checkOutput("rst_gnt0", m0_gnt, 0);
    checkOutput("rst_gnt1", m1_gnt, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_wdata", ram_wdata, 0);
    checkOutput("rst_rvalid0", m0_rvalid, 0);
    checkOutput("rst_rvalid1", m1_rvalid, 0);
    checkOutput("rst_rdata0", m0_rdata, 0);
    checkOutput("rst_rdata1", m1_rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;

    // m0 write then read-back of the same address.
    step();
    applyStimulus(1, 1, 32'h2000_0000, 32'hDEAD_BEEF, 0, 0, 0, 0);
    checkOutput("wr_gnt0", m0_gnt, 1);
    checkOutput("wr_ram_we", ram_we, 1);
    checkOutput("wr_ram_addr", ram_addr, 32'h2000_0000);
    checkOutput("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    step();
    applyStimulus(1, 0, 32'h2000_0000, 0, 0, 0, 0, 0);
    checkOutput("rd_gnt0", m0_gnt, 1);
    checkOutput("rd_ram_we", ram_we, 0);
    checkOutput("wr_no_rvalid", m0_rvalid, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd_rvalid0", m0_rvalid, 1);
    checkOutput("rd_rdata0", m0_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_rvalid1", m1_rvalid, 0);
    checkOutput("idle_ram_addr", ram_addr, 0);

    // m1 write with m0 idle, then an idle cycle.
    step();
    checkOutput("rvalid0_one_cycle", m0_rvalid, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h2000_0004, 32'h1234_5678);
    checkOutput("m1wr_gnt1", m1_gnt, 1);
    checkOutput("m1wr_gnt0", m0_gnt, 0);
    checkOutput("m1wr_ram_we", ram_we, 1);
    checkOutput("m1wr_ram_addr", ram_addr, 32'h2000_0004);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_ram_we", ram_we, 0);
    checkOutput("idle_ram_addr2", ram_addr, 0);
    checkOutput("m1wr_mem1", mem[1], 32'h1234_5678);
    checkOutput("m1wr_no_rvalid", m1_rvalid, 0);

    // Both masters read every cycle.
    prev0 = 1'b0;
    prev1 = 1'b0;
    for (int c = 0; c < 18; c++) begin
      step();
      applyStimulus(1, 0, 32'h2000_0008, 0, 1, 0, 32'h2000_000C, 0);
`ifdef RAM_ARB_RR_EN
      exp1 = (c % 2 == 1);
`else
      exp1 = (c % 9 == 8);
`endif
      checkOutput($sformatf("both_gnt0_c%0d", c), m0_gnt, !exp1);
      checkOutput($sformatf("both_gnt1_c%0d", c), m1_gnt, exp1);
      checkOutput($sformatf("both_rvalid0_c%0d", c), m0_rvalid, prev0);
      checkOutput($sformatf("both_rvalid1_c%0d", c), m1_rvalid, prev1);
      if (prev0) checkOutput($sformatf("both_rdata0_c%0d", c), m0_rdata, 32'hA000_0002);
      if (prev1) checkOutput($sformatf("both_rdata1_c%0d", c), m1_rdata, 32'hA000_0003);
      prev0 = !exp1;
      prev1 = exp1;
    end

    // Build up starvation, then reset with both still requesting.
    for (int c = 0; c < 5; c++) begin
      step();
      applyStimulus(1, 0, 32'h2000_0008, 0, 1, 0, 32'h2000_000C, 0);
    end
    step();
    rst = 1'b1;
    #1;
    checkOutput("rstmid_gnt0", m0_gnt, 0);
    checkOutput("rstmid_gnt1", m1_gnt, 0);
    checkOutput("rstmid_ram_addr", ram_addr, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      applyStimulus(1, 0, 32'h2000_0008, 0, 1, 0, 32'h2000_000C, 0);
      if (c == 0) begin
        checkOutput("postrst_rvalid0", m0_rvalid, 0);
        checkOutput("postrst_rvalid1", m1_rvalid, 0);
        checkOutput("postrst_rdata0", m0_rdata, 0);
        checkOutput("postrst_rdata1", m1_rdata, 0);
      end
`ifdef RAM_ARB_RR_EN
      exp1 = (c % 2 == 1);
`else
      exp1 = (c == 8);
`endif
      checkOutput($sformatf("postrst_gnt1_c%0d", c), m1_gnt, exp1);
    end

    // Long m0-only burst, then m1 alone is granted immediately.
    for (int c = 0; c < 12; c++) begin
      step();
      applyStimulus(1, 0, 32'h2000_0008, 0, 0, 0, 0, 0);
    end
    checkOutput("burst_gnt0", m0_gnt, 1);
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h2000_0014, 0);
    checkOutput("lone_gnt1", m1_gnt, 1);
    checkOutput("lone_gnt0", m0_gnt, 0);
    step();
    applyStimulus(1, 0, 32'h2000_0008, 0, 1, 0, 32'h2000_000C, 0);
    checkOutput("lone_rvalid1", m1_rvalid, 1);
    checkOutput("lone_rdata1", m1_rdata, 32'hA000_0005);
`ifdef RAM_ARB_RR_EN
    checkOutput("after_lone_gnt0", m0_gnt, 1);
`else
    checkOutput("after_lone_gnt0", m0_gnt, 1);
    checkOutput("after_lone_gnt1", m1_gnt, 0);
`endif
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port data RAM between the core load/store unit (master 0) and a debug/loader port (master 1, UART loader or testbench DMA). It sits between the core memory interface and `ram`. It grants at most one access per cycle and drives the RAM's write enable, address and write data. For read grants it captures the RAM's combinational read data and returns it to the winning master one cycle later.

## Interface
Parameters:
- `DW`, 32, data width (matches `MEM_BUS`).
- `AW`, 32, address width (matches `MEM_ADDR_BUS`).
- `STARVE_LIMIT`, 8, fixed-priority mode only: number of consecutive denied cycles before master 1 is promoted. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req_i` / `m1_req_i`  in  1  access request; address, `we` and wdata must be held stable until `gnt`.
- `m0_we_i` / `m1_we_i`  in  1  1 = write, 0 = read.
- `m0_addr_i` / `m1_addr_i`  in  AW  byte address, passed to the RAM unmodified.
- `m0_wdata_i` / `m1_wdata_i`  in  DW  write data.
- `m0_gnt_o` / `m1_gnt_o`  out  1  combinational grant; the access is taken at the next rising edge.
- `m0_rvalid_o` / `m1_rvalid_o`  out  1  registered; high exactly one cycle after a read grant.
- `m0_rdata_o` / `m1_rdata_o`  out  DW  registered read data; valid while the matching `rvalid` is high.
- `ram_we_o`  out  1  RAM write enable.
- `ram_addr_o`  out  AW  RAM address.
- `ram_wdata_o`  out  DW  RAM write data.
- `ram_rdata_i`  in  DW  combinational RAM read data for `ram_addr_o`.

## Operation
- Each cycle, pick at most one requester. `gnt_o` is a combinational function of the `req` inputs and the arbitration state.
- With no grant, `ram_we_o`=0, `ram_addr_o`=0 and `ram_wdata_o`=0, so the arbiter never issues a spurious write.
- Granted write: `ram_we_o`=`mX_we_i`, and the address and data are muxed from master X. The write commits at the edge. No `rvalid` is generated; the master treats the grant as completion.
- Granted read: `ram_rdata_i` is latched into `mX_rdata_o` at the edge and `mX_rvalid_o`=1 for the following cycle. The other master's `rdata` holds its previous value.
- Arbitration in fixed-priority mode (default):
  - Master 0 wins, except when starvation promotion is active.
  - Starve counter: 8 bits, saturating. It increments each cycle `m1_req_i`=1 and `m1_gnt_o`=0.
  - The counter clears on an m1 grant or when `m1_req_i`=0.
  - While the counter is ≥ `STARVE_LIMIT`, master 1 wins over master 0.
- Simultaneous requests resolve per the above. A lone requester is always granted the same cycle.
- Back-to-back: a write granted at cycle N followed by a read of the same address at N+1 returns the new data.
- Reset (any cycle, including mid-access): gnts=0, RAM outputs zeroed, `rvalid`=0, `rdata`=0, starve counter=0, RR pointer=0. A read granted in the cycle of the reset edge is dropped, with no `rvalid`.

## Timing
- Grant latency: 0 cycles (combinational).
- Read data latency: 1 cycle from grant.
- Write latency: commits at the grant edge.
- Throughput: one access per cycle in total across both masters.
- Reset values: all outputs 0.
- Worst-case m0 wait: 1 cycle, when m1 is promoted. Worst-case m1 wait: `STARVE_LIMIT` cycles.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin mode.
  - A 1-bit last-grant pointer is updated on every grant.
  - On simultaneous requests, the master not granted last wins.
  - The starve counter logic is compiled out and `STARVE_LIMIT` is ignored.
- `RAM_ARB_RR_EN` undefined: fixed priority with starvation promotion, as described under Operation.

## Structure
- Add to `defines.v`:
  - `ARB_M0` (1'b0) and `ARB_M1` (1'b1) grant encodings.
  - `ARB_CNT_BUS` (7:0) for the starve counter.
  - Reuse `MEM_BUS`, `MEM_ADDR_BUS`, `ZERO_WORD`, `WRITE_ENABLE`.
- One sub-module, `arb_pick2`: combinational winner selection from (req0, req1, prefer1) to (gnt0, gnt1). The top level computes `prefer1` from the starve counter or the RR pointer.
- Datapath muxes and the rdata/rvalid registers live in `ram_arbiter`.

## Test plan
- m0 write 0x20000000←0xDEADBEEF, then m0 read of the same address next cycle -> `m0_gnt` both cycles; `m0_rvalid`=1 with 0xDEADBEEF one cycle after the read grant.
- m0 and m1 both request reads every cycle, fixed mode, `STARVE_LIMIT`=8:
  - m0 granted cycles 0–7, m1 granted cycle 8, pattern repeats.
  - `m1_rvalid` at cycle 9.
- Same stimulus with `RAM_ARB_RR_EN` -> grants alternate m0, m1, m0, …; each `rvalid` arrives one cycle after its own grant, only to its owner.
- m1 write 0x20000004←0x12345678 while m0 is idle -> `ram_we_o`=1 for exactly that cycle. An idle cycle follows with `ram_we_o`=0 and `ram_addr_o`=0, and RAM word 1 holds 0x12345678.
- Assert `rst` in the cycle m0's read is granted -> no `m0_rvalid` the next cycle; all outputs 0; starve counter 0.
- m1 requests alone after a long m0-only burst -> granted in the same cycle; starve counter stays 0.
